// File: rtl/aes_pkg.sv
// Shared AES byte-state helpers, GF(2^8)/GF(2^4) arithmetic and FSM type.
// Composite-field basis tables are derived from the field polynomials.
package aes_pkg;

  localparam int STATE_W  = 128;
  localparam int BYTE_W   = 8;
  localparam int NB_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef logic [NB_BYTES-1:0][BYTE_W-1:0] aes_state_t;

  function automatic logic [3:0] byte_idx(input int r, input int c);
    return 4'(r + 4 * c);
  endfunction

  // Byte 0 sits in the most significant lane of the packed state.
  function automatic logic [3:0] slot(input logic [3:0] i);
    return 4'(NB_BYTES - 1) - i;
  endfunction

  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[slot(byte_idx(r, c))] = s[slot(byte_idx(r, (c + 4 - r) % 4))];
    return o;
  endfunction

  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[slot(byte_idx(r, c))] = s[slot(byte_idx(r, (c + r) % 4))];
    return o;
  endfunction

  function automatic logic [7:0] gmul8(input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // GF(2^4) over z^4 + z + 1.
  function automatic logic [3:0] gmul4(input logic [3:0] a,
                                       input logic [3:0] b);
    logic [3:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] inv4(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gmul4(a, a);
    a4 = gmul4(a2, a2);
    a8 = gmul4(a4, a4);
    return gmul4(gmul4(a2, a4), a8);
  endfunction

  function automatic logic [7:0] lin_map(input logic [63:0] m,
                                         input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++)
      if (x[k]) r ^= m[8*k +: 8];
    return r;
  endfunction

  // Smallest lambda making Y^2 + Y + lambda irreducible over GF(2^4).
  function automatic logic [3:0] find_lambda();
    logic [3:0] l;
    logic       hit;
    l = '0;
    for (int v = 15; v > 0; v--) begin
      hit = 1'b0;
      for (int t = 0; t < 16; t++)
        if ((gmul4(4'(t), 4'(t)) ^ 4'(t)) == 4'(v)) hit = 1'b1;
      if (!hit) l = 4'(v);
    end
    return l;
  endfunction

  // A root of z^4 + z + 1 inside GF(2^8).
  function automatic logic [7:0] find_zeta();
    logic [7:0] z, e, e2;
    z = '0;
    for (int v = 255; v > 1; v--) begin
      e  = 8'(v);
      e2 = gmul8(e, e);
      if ((gmul8(e2, e2) ^ e ^ 8'h01) == 8'h00) z = e;
    end
    return z;
  endfunction

  // Columns: images of z^j and Y*z^j in the polynomial basis.
  function automatic logic [63:0] build_iso_inv(input logic [3:0] lam4,
                                                input logic [7:0] zeta);
    logic [63:0] m;
    logic [7:0]  zp, lam, y, e;
    m   = '0;
    zp  = 8'h01;
    lam = '0;
    for (int j = 0; j < 4; j++) begin
      m[8*j +: 8] = zp;
      if (lam4[j]) lam ^= zp;
      zp = gmul8(zp, zeta);
    end
    y = '0;
    for (int v = 255; v > 0; v--) begin
      e = 8'(v);
      if ((gmul8(e, e) ^ e ^ lam) == 8'h00) y = e;
    end
    zp = y;
    for (int j = 4; j < 8; j++) begin
      m[8*j +: 8] = zp;
      zp = gmul8(zp, zeta);
    end
    return m;
  endfunction

  function automatic logic [63:0] build_iso_fwd(input logic [63:0] inv_m);
    logic [63:0] f;
    logic [7:0]  v;
    f = '0;
    for (int c = 1; c < 256; c++) begin
      v = lin_map(inv_m, 8'(c));
      for (int k = 0; k < 8; k++)
        if (v == (8'h01 << k)) f[8*k +: 8] = 8'(c);
    end
    return f;
  endfunction

  localparam logic [3:0]  GF4_LAMBDA = find_lambda();
  localparam logic [7:0]  GF_ZETA    = find_zeta();
  localparam logic [63:0] ISO_INV    = build_iso_inv(GF4_LAMBDA, GF_ZETA);
  localparam logic [63:0] ISO_FWD    = build_iso_fwd(ISO_INV);

  function automatic logic [7:0] inv_affine(input logic [7:0] y);
    logic [7:0] o;
    for (int i = 0; i < 8; i++)
      o[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8];
    return o ^ 8'h05;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    logic [7:0] o;
    for (int i = 0; i < 8; i++)
      o[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8]
           ^ x[(i+6)%8] ^ x[(i+7)%8];
    return o ^ 8'h63;
  endfunction

endpackage

// File: rtl/inv_sbox_lane.sv
// One combinational AES S-box lane using GF((2^4)^2) inversion.
// With FWD_MODE_EN the lane also carries the forward affine, picked by mode_i.
module inv_sbox_lane
  import aes_pkg::*;
(
`ifdef FWD_MODE_EN
  input  logic       mode_i,
`endif
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  logic [7:0] pre;
  logic [7:0] iso;
  logic [7:0] inv_c;
  logic [7:0] inv_s;
  logic [3:0] ah;
  logic [3:0] al;
  logic [3:0] dlt;
  logic [3:0] dinv;

`ifdef FWD_MODE_EN
  assign pre = mode_i ? inv_affine(byte_i) : byte_i;
`else
  assign pre = inv_affine(byte_i);
`endif

  assign iso = lin_map(ISO_FWD, pre);
  assign ah  = iso[7:4];
  assign al  = iso[3:0];

  // (ah*Y + al)^-1 = (ah*Y + ah + al) / (ah^2*lambda + ah*al + al^2)
  assign dlt = gmul4(gmul4(ah, ah), GF4_LAMBDA)
             ^ gmul4(ah, al)
             ^ gmul4(al, al);
  assign dinv  = inv4(dlt);
  assign inv_c = {gmul4(ah, dinv), gmul4(ah ^ al, dinv)};
  assign inv_s = lin_map(ISO_INV, inv_c);

`ifdef FWD_MODE_EN
  assign byte_o = mode_i ? inv_s : fwd_affine(inv_s);
`else
  assign byte_o = inv_s;
`endif

endmodule

// File: rtl/inv_sub_shift_engine.sv
// InvShiftRows + InvSubBytes engine, LANES bytes per cycle, valid/ready both sides.
// Define FWD_MODE_EN to add a mode port selecting ShiftRows + SubBytes (mode=0).
module inv_sub_shift_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef FWD_MODE_EN
  input  logic         mode,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N  = NB_BYTES / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (NB_BYTES % LANES != 0) begin : g_bad_lanes
    $error("inv_sub_shift_engine: LANES must divide 16");
  end

  state_e     state_q, state_d;
  aes_state_t work_q, work_d;
  aes_state_t out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

`ifdef FWD_MODE_EN
  logic mode_q, mode_d;
`endif

  logic [BYTE_W-1:0] lane_in  [LANES];
  logic [BYTE_W-1:0] lane_out [LANES];
  logic [3:0]        lane_idx [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
      lane_in[l]  = work_q[slot(lane_idx[l])];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox_lane u_lane (
`ifdef FWD_MODE_EN
      .mode_i (mode_q),
`endif
      .byte_i (lane_in[g]),
      .byte_o (lane_out[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
`ifdef FWD_MODE_EN
    mode_d    = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef FWD_MODE_EN
          mode_d = mode;
          work_d = mode ? inv_shift_rows(in_state)
                        : shift_rows(in_state);
`else
          work_d = inv_shift_rows(in_state);
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++)
          work_d[slot(lane_idx[l])] = lane_out[l];
        if (cnt_q == CW'(N - 1)) begin
          out_d   = work_d;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
`ifdef FWD_MODE_EN
      mode_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
`ifdef FWD_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign out_state = out_q;

endmodule

// File: tb/tb_inv_sub_shift_engine.sv
// Scoreboard bench for inv_sub_shift_engine with LANES = 4, 1 and 16.
// Stimulus pushes expected states; a negedge monitor pops on each out handshake.
module tb_inv_sub_shift_engine;

  localparam int ND = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic [127:0] in_state  [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic [127:0] out_state [ND];
  logic         busy      [ND];
`ifdef FWD_MODE_EN
  logic         mode;
`endif

  logic [127:0] exp_q [ND][$];
  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  inv_sub_shift_engine #(.LANES(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FWD_MODE_EN
    .mode      (mode),
`endif
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_state  (in_state[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_state (out_state[0]),
    .busy      (busy[0])
  );

  inv_sub_shift_engine #(.LANES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FWD_MODE_EN
    .mode      (mode),
`endif
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_state  (in_state[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_state (out_state[1]),
    .busy      (busy[1])
  );

  inv_sub_shift_engine #(.LANES(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FWD_MODE_EN
    .mode      (mode),
`endif
    .in_valid  (in_valid[2]),
    .in_ready  (in_ready[2]),
    .in_state  (in_state[2]),
    .out_valid (out_valid[2]),
    .out_ready (out_ready[2]),
    .out_state (out_state[2]),
    .busy      (busy[2])
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [127:0] put_b(input logic [127:0] s,
                                         input int i,
                                         input logic [7:0] b);
    logic [127:0] r;
    r = s;
    r[127-8*i -: 8] = b;
    return r;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst_n && out_valid[d] && out_ready[d]) begin
        if (exp_q[d].size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_out%0d: got %h required none",
                   d, out_state[d]);
        end else begin
          chk($sformatf("out_state%0d", d), out_state[d],
              exp_q[d].pop_front());
        end
      end
    end
  end

  task automatic accept(input int d, input logic [127:0] st,
                        input logic [127:0] ex, input bit push);
    int w;
    w = 0;
    while (!in_ready[d] && w < 64) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready[d]) chk($sformatf("accept_wait%0d", d),
                          128'(in_ready[d]), 128'd1);
    in_valid[d] = 1'b1;
    in_state[d] = st;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    if (push) exp_q[d].push_back(ex);
  endtask

  task automatic wait_out(input int d, input int lat, input string nm);
    int n;
    n = 0;
    while (!out_valid[d] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 128'(n), 128'(lat));
    chk({nm, "_ready_busy"}, {126'b0, in_ready[d], busy[d]}, 128'd0);
  endtask

  logic [127:0] v, e;
  int lat_of [ND];

  initial begin
    lat_of[0] = 4;
    lat_of[1] = 16;
    lat_of[2] = 1;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      in_state[d]  = '0;
      out_ready[d] = 1'b1;
    end
`ifdef FWD_MODE_EN
    mode = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset_flags%0d", d),
          {125'b0, in_ready[d], out_valid[d], busy[d]}, 128'd4);
      chk($sformatf("reset_out%0d", d), out_state[d], 128'd0);
    end

    accept(0, fill(8'h63), 128'd0, 1'b1);
    chk("run_flags", {126'b0, in_ready[0], busy[0]}, 128'd1);
    wait_out(0, 4, "all63");

    v = put_b(fill(8'h63), 1, 8'h7c);
    e = put_b(128'd0, 5, 8'h01);
    accept(0, v, e, 1'b1);
    wait_out(0, 4, "row1");

    v = put_b(put_b(fill(8'h63), 0, 8'h16), 4, 8'hed);
    v = put_b(put_b(v, 8, 8'h63), 12, 8'hed);
    e = put_b(put_b(128'd0, 0, 8'hff), 4, 8'h53);
    e = put_b(e, 12, 8'h53);
    for (int d = 0; d < ND; d++) begin
      accept(d, v, e, 1'b1);
      wait_out(d, lat_of[d], $sformatf("row0_d%0d", d));
    end

    v = put_b(put_b(fill(8'h63), 2, 8'h7c), 3, 8'h16);
    v = put_b(v, 13, 8'h16);
    e = put_b(put_b(128'd0, 10, 8'h01), 15, 8'hff);
    e = put_b(e, 1, 8'hff);
    for (int d = 0; d < 2; d++) begin
      accept(d, v, e, 1'b1);
      wait_out(d, lat_of[d], $sformatf("rows_d%0d", d));
    end

    out_ready[0] = 1'b0;
    v = put_b(fill(8'h63), 1, 8'h7c);
    e = put_b(128'd0, 5, 8'h01);
    accept(0, v, e, 1'b1);
    wait_out(0, 4, "bp");
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      in_state[0] = fill(8'h16);
      @(posedge clk); #1;
      chk("bp_hold_state", out_state[0], e);
      chk("bp_hold_flags",
          {125'b0, out_valid[0], in_ready[0], busy[0]}, 128'd4);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {125'b0, out_valid[0], in_ready[0], busy[0]},
        128'd2);
    @(posedge clk); #1;
    chk("bp_no_accept", {126'b0, in_ready[0], busy[0]}, 128'd2);

    accept(0, fill(8'h16), 128'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_flags", {125'b0, in_ready[0], out_valid[0], busy[0]},
        128'd4);
    chk("abort_out", out_state[0], 128'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_quiet", {126'b0, out_valid[0], busy[0]}, 128'd0);
    accept(0, fill(8'h63), 128'd0, 1'b1);
    wait_out(0, 4, "post_rst");

`ifdef FWD_MODE_EN
    mode = 1'b0;
    accept(0, 128'd0, fill(8'h63), 1'b1);
    wait_out(0, 4, "fwd_zero");
    accept(0, put_b(128'd0, 0, 8'h53),
           put_b(fill(8'h63), 0, 8'hed), 1'b1);
    wait_out(0, 4, "fwd_b0");
    accept(0, put_b(128'd0, 1, 8'h53),
           put_b(fill(8'h63), 13, 8'hed), 1'b1);
    wait_out(0, 4, "fwd_row1");
    mode = 1'b1;
`endif

    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++)
      chk($sformatf("drain%0d", d), 128'(exp_q[d].size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
